// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Two-requester byte arbiter in front of a UART transmit engine. A byte is
// accepted from one requester when the transmitter reports ready, presented to
// the engine with a one-cycle load strobe, and the arbiter then follows the
// engine's txrdy level: it must fall (frame started) and rise again (frame
// done) before the next byte can be accepted. If txrdy never falls after a
// load, a sticky timeout flag is raised and the arbiter returns to idle.
//
// Parameters
//   RR         1 = round-robin between the requesters, 0 = requester 0 always
//              wins contention.
//   TMO        cycles allowed for txrdy to fall after the load strobe (>= 1).
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset_n    asynchronous active-low reset
//   req0_valid requester 0 has a byte
//   req0_data  requester 0 byte
//   req0_ready requester 0 byte accepted this cycle (combinational)
//   req1_*     same for requester 1
//   txrdy      transmitter-ready level from the tx engine
//   load       one-cycle load strobe to the tx engine (registered)
//   out_data   byte presented to the tx engine (registered)
//   grant_id   requester whose byte is in flight (registered)
//   busy       high whenever the arbiter is not idle (registered)
//   clr_err    synchronous clear of err_tmo
//   err_tmo    sticky timeout flag (registered)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int RR  = 1,
  parameter int TMO = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic       txrdy,
  output logic       load,
  output logic [7:0] out_data,
  output logic       grant_id,
  output logic       busy,
  input  logic       clr_err,
  output logic       err_tmo
);

  // Timeout counter only has to reach TMO-1, so clog2(TMO) bits suffice.
  localparam int            CW       = (TMO < 2) ? 1 : $clog2(TMO);
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);
  localparam logic          RR_EN    = (RR != 0);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOAD    = 2'd1;
  localparam logic [1:0] ST_WAIT_LO = 2'd2;
  localparam logic [1:0] ST_WAIT_HI = 2'd3;

  logic [1:0]    state_q,    state_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          gid_q,      gid_d;
  logic          ptr_q,      ptr_d;
  logic          load_q,     load_d;
  logic          busy_q,     busy_d;
  logic          err_q,      err_d;

  logic          any_req_s;
  logic          winner_s;
  logic          grant_s;
  logic          tmo_set_s;

  // Arbitration: pick the winning requester and decide whether a grant happens now.
  always_comb begin
    any_req_s = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      // Contention: the pointer decides in round-robin mode, requester 0 otherwise.
      if (RR_EN) begin
        winner_s = ptr_q;
      end else begin
        winner_s = 1'b0;
      end
    end else if (req1_valid) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
    // Gated with reset_n so both readys are low while reset is held, even
    // though the state register already reads IDLE.
    grant_s = reset_n & (state_q == ST_IDLE) & txrdy & any_req_s;
  end

  // Ready outputs: combinational, at most one high, only in a granting IDLE cycle.
  always_comb begin
    req0_ready = grant_s & ~winner_s;
    req1_ready = grant_s &  winner_s;
  end

  // Next-state logic for the transfer FSM, capture registers and timeout counter.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    gid_d      = gid_q;
    ptr_d      = ptr_q;
    tmo_set_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_s) begin
          state_d    = ST_LOAD;
          out_data_d = winner_s ? req1_data : req0_data;
          gid_d      = winner_s;
          // Pointer prefers whoever did not just win.
          ptr_d      = ~winner_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_d = ST_WAIT_LO;
        cnt_d   = '0;
      end
      ST_WAIT_LO: begin
        if (!txrdy) begin
          state_d = ST_WAIT_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // txrdy stayed high for TMO cycles in this state: give up.
          tmo_set_s = 1'b1;
          state_d   = ST_IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_HI: begin
        // Frame length depends on baud rate, so no timeout here.
        if (txrdy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_HI;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered-output next values; a timeout set beats a same-cycle clear.
  always_comb begin
    load_d = (state_d == ST_LOAD);
    busy_d = (state_d != ST_IDLE);
    if (tmo_set_s) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      out_data_q <= 8'h00;
      gid_q      <= 1'b0;
      ptr_q      <= 1'b0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      gid_q      <= gid_d;
      ptr_q      <= ptr_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign load     = load_q;
  assign out_data = out_data_q;
  assign grant_id = gid_q;
  assign busy     = busy_q;
  assign err_tmo  = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Drives one round-robin instance (index 0) and one fixed-priority instance
// (index 1) from shared inputs. A transaction-level model tracks, per
// instance, whether a transfer is in flight and which phase of the engine
// handshake it has reached, and predicts every output each cycle. Directed
// sequences cover single transfer, contention, blocked idle, timeout, clear
// versus set, and reset abort; a random phase follows.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int TMO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       v0, v1, txrdy, clr;
  logic [7:0] d0, d1;
  logic [1:0] rdy0, rdy1, ld, gid, bsy, err;
  logic [7:0] od [2];

  uart_tx_arbiter #(.RR(1), .TMO(TMO)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(v0), .req0_data(d0), .req0_ready(rdy0[0]),
    .req1_valid(v1), .req1_data(d1), .req1_ready(rdy1[0]),
    .txrdy(txrdy), .load(ld[0]), .out_data(od[0]), .grant_id(gid[0]),
    .busy(bsy[0]), .clr_err(clr), .err_tmo(err[0])
  );

  uart_tx_arbiter #(.RR(0), .TMO(TMO)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(v0), .req0_data(d0), .req0_ready(rdy0[1]),
    .req1_valid(v1), .req1_data(d1), .req1_ready(rdy1[1]),
    .txrdy(txrdy), .load(ld[1]), .out_data(od[1]), .grant_id(gid[1]),
    .busy(bsy[1]), .clr_err(clr), .err_tmo(err[1])
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model, one slot per instance.
  bit         m_act  [2];   // transfer in flight
  bit         m_ld   [2];   // load strobe cycle pending
  bit         m_fell [2];   // txrdy seen low since the load
  int         m_hi   [2];   // cycles txrdy stayed high while waiting to fall
  bit         m_ptr  [2];
  bit         m_err  [2];
  bit         m_gid  [2];
  logic [7:0] m_dat  [2];

  logic [8:0] log_rr[$];
  logic [8:0] log_fp[$];
  bit         fp_r1_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit pick(input int i, input bit a, input bit b);
    if (a && b) return (i == 0) ? m_ptr[i] : 1'b0;
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_ld[i] = 0; m_fell[i] = 0; m_hi[i] = 0;
      m_ptr[i] = 0; m_err[i] = 0; m_gid[i] = 0; m_dat[i] = 8'h00;
    end
  endtask

  task automatic model_edge(input int i);
    bit w;
    bit set_e;
    set_e = 0;
    if (!m_act[i]) begin
      if (txrdy && (v0 || v1)) begin
        w = pick(i, v0, v1);
        m_act[i] = 1; m_ld[i] = 1; m_fell[i] = 0; m_hi[i] = 0;
        m_gid[i] = w; m_dat[i] = w ? d1 : d0; m_ptr[i] = !w;
      end
    end else if (m_ld[i]) begin
      m_ld[i] = 0;
    end else if (!m_fell[i]) begin
      if (!txrdy) m_fell[i] = 1;
      else begin
        m_hi[i]++;
        if (m_hi[i] == TMO) begin
          set_e = 1;
          m_act[i] = 0;
        end
      end
    end else if (txrdy) begin
      m_act[i] = 0;
    end
    if (set_e) m_err[i] = 1;
    else if (clr) m_err[i] = 0;
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      bit g;
      bit w;
      g = reset_n && !m_act[i] && txrdy && (v0 || v1);
      w = pick(i, v0, v1);
      check($sformatf("req0_ready[%0d]", i), rdy0[i], g && !w);
      check($sformatf("req1_ready[%0d]", i), rdy1[i], g && w);
      check($sformatf("load[%0d]", i), ld[i], m_ld[i]);
      check($sformatf("busy[%0d]", i), bsy[i], m_act[i]);
      check($sformatf("out_data[%0d]", i), od[i], m_dat[i]);
      check($sformatf("grant_id[%0d]", i), gid[i], m_gid[i]);
      check($sformatf("err_tmo[%0d]", i), err[i], m_err[i]);
      if (ld[i] === 1'b1) begin
        if (i == 0) log_rr.push_back({gid[i], od[i]});
        else        log_fp.push_back({gid[i], od[i]});
      end
      if (i == 1 && rdy1[1] === 1'b1) fp_r1_seen = 1;
    end
  endtask

  // One clock: check on the falling edge, advance the model on the rising edge.
  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  // Called 1 ns after a rising edge; returns 2 ns after the next one.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_req0_ready[%0d]", i), rdy0[i], 1'b0);
      check($sformatf("rst_req1_ready[%0d]", i), rdy1[i], 1'b0);
      check($sformatf("rst_load[%0d]", i), ld[i], 1'b0);
      check($sformatf("rst_busy[%0d]", i), bsy[i], 1'b0);
      check($sformatf("rst_out_data[%0d]", i), od[i], 8'h00);
      check($sformatf("rst_grant_id[%0d]", i), gid[i], 1'b0);
      check($sformatf("rst_err_tmo[%0d]", i), err[i], 1'b0);
    end
    model_reset();
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    int base;
    logic [8:0] exp_rr [4];
    reset_n = 1'b1;
    v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00; txrdy = 1'b0; clr = 1'b0;
    fp_r1_seen = 0;
    do_reset();

    // Blocked idle: txrdy low with both valid, then one grant to requester 0.
    v0 = 1'b1; v1 = 1'b1; d0 = 8'h3C; d1 = 8'hC3; txrdy = 1'b0;
    repeat (10) step();
    check("blocked_no_load", log_rr.size() + log_fp.size(), 0);
    txrdy = 1'b1;
    step();
    check("blocked_load_rr", ld[0], 1'b1);
    check("blocked_gid_rr", gid[0], 1'b0);
    check("blocked_gid_fp", gid[1], 1'b0);
    v0 = 1'b0; v1 = 1'b0;
    step();
    txrdy = 1'b0; step();
    txrdy = 1'b1; step();
    check("blocked_one_grant_rr", log_rr.size(), 1);
    check("blocked_one_grant_fp", log_fp.size(), 1);

    // Contention: round-robin alternates, fixed priority always serves 0.
    do_reset();
    log_rr.delete(); log_fp.delete(); fp_r1_seen = 0;
    v0 = 1'b1; v1 = 1'b1; d0 = 8'h11; d1 = 8'h22;
    for (int k = 0; k < 16; k++) begin
      txrdy = ((k % 4) != 2);
      step();
    end
    v0 = 1'b0; v1 = 1'b0;
    exp_rr[0] = {1'b0, 8'h11}; exp_rr[1] = {1'b1, 8'h22};
    exp_rr[2] = {1'b0, 8'h11}; exp_rr[3] = {1'b1, 8'h22};
    check("rr_grant_count", log_rr.size(), 4);
    check("fp_grant_count", log_fp.size(), 4);
    for (int j = 0; j < 4; j++) begin
      if (j < log_rr.size()) check($sformatf("rr_seq%0d", j), log_rr[j], exp_rr[j]);
      if (j < log_fp.size()) check($sformatf("fp_seq%0d", j), log_fp[j], {1'b0, 8'h11});
    end
    check("fp_req1_ready_never", fp_r1_seen, 1'b0);

    // Single request.
    txrdy = 1'b1; v0 = 1'b1; d0 = 8'hA5;
    step();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("single_load[%0d]", i), ld[i], 1'b1);
      check($sformatf("single_data[%0d]", i), od[i], 8'hA5);
      check($sformatf("single_gid[%0d]", i), gid[i], 1'b0);
    end
    v0 = 1'b0;
    step();
    check("single_busy_wlo", bsy[0], 1'b1);
    txrdy = 1'b0; step();
    step();
    check("single_busy_whi", bsy[0], 1'b1);
    txrdy = 1'b1; step();
    check("single_idle", bsy[0], 1'b0);

    // Timeout, clear, and clear colliding with a timeout set.
    v0 = 1'b1; d0 = 8'h5A;
    step();
    v0 = 1'b0;
    step();
    repeat (TMO - 1) step();
    check("tmo_early", err[0], 1'b0);
    step();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("tmo_err[%0d]", i), err[i], 1'b1);
      check($sformatf("tmo_idle[%0d]", i), bsy[i], 1'b0);
    end
    clr = 1'b1; step(); clr = 1'b0;
    check("tmo_clear", err[0], 1'b0);
    v0 = 1'b1; d0 = 8'h77;
    step();
    v0 = 1'b0;
    step();
    clr = 1'b1;
    repeat (TMO) step();
    check("tmo_set_wins_rr", err[0], 1'b1);
    check("tmo_set_wins_fp", err[1], 1'b1);
    step();
    clr = 1'b0;
    check("tmo_clear2", err[0], 1'b0);

    // Reset abort during WAIT_HI.
    v0 = 1'b1; d0 = 8'h9E;
    step();
    v0 = 1'b0;
    step();
    txrdy = 1'b0;
    step();
    step();
    txrdy = 1'b1; v0 = 1'b1;
    do_reset();
    txrdy = 1'b0;
    base = log_rr.size();
    repeat (5) step();
    check("abort_no_load", log_rr.size() - base, 0);
    txrdy = 1'b1;
    step();
    check("abort_load_rr", ld[0], 1'b1);
    check("abort_load_fp", ld[1], 1'b1);
    v0 = 1'b0; step();
    txrdy = 1'b0; step();
    txrdy = 1'b1; step();

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      v0    = ($urandom_range(0, 99) < 60);
      v1    = ($urandom_range(0, 99) < 60);
      d0    = 8'($urandom);
      d1    = 8'($urandom);
      txrdy = ($urandom_range(0, 99) < 65);
      clr   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
